// File: rtl/ulx3s_pll_phase_stepper_if.sv
// Request/status handshake between a phase-trim client and the ULX3S PLL phase stepper.
interface ulx3s_pll_phase_stepper_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       done;
  logic       err;
  logic       busy;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, done, err, busy
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, done, err, busy
  );
endinterface

// File: rtl/ulx3s_pll_phase_stepper.sv
// Sequences the ECP5 EHXPLLL dynamic phase-shift strobes (PHASESEL/PHASEDIR/PHASESTEP),
// tracks the accumulated step count of each PLL output and waits for LOCK before completing.
module ulx3s_pll_phase_stepper #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  ulx3s_pll_phase_stepper_if.slave req_if,
  output logic [31:0]              phase_count,
  input  logic                     pll_locked,
  output logic [1:0]               pll_phasesel,
  output logic                     pll_phasedir,
  output logic                     pll_phasestep,
  output logic                     pll_phaseloadreg
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STEP_LOW  = 3'd2,
    ST_STEP_HIGH = 3'd3,
    ST_WAIT_LOCK = 3'd4
  } state_t;

  localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LAST   = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_rem;
  logic [1:0]  r_sel;
  logic        r_dir;
  logic        r_step;
  logic [31:0] r_count;
  logic        r_done;
  logic        r_err;
  logic        r_busy;
  logic        r_ready;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_rem_next;
  logic [1:0]  w_sel_next;
  logic        w_dir_next;
  logic        w_step_next;
  logic [31:0] w_count_next;
  logic        w_done_next;
  logic        w_err_next;
  logic        w_busy_next;
  logic        w_ready_next;
  logic        w_accept;
  logic        w_enter_low;

  // Moves one 8-bit lane of the packed counters by one step, wrapping modulo 256.
  function automatic logic [31:0] step_counter(input logic [31:0] counts,
                                               input logic [1:0]  sel,
                                               input logic        dir);
    logic [31:0] result;
    logic [7:0]  lane;
    result = counts;
    lane   = counts[{sel, 3'b000} +: 8];
    if (dir) begin
      lane = lane - 8'd1;
    end else begin
      lane = lane + 8'd1;
    end
    result[{sel, 3'b000} +: 8] = lane;
    return result;
  endfunction

  assign w_accept = req_if.req_valid && r_ready && (r_state == ST_IDLE);

  // Next-state and next-output logic of the stepping sequence.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 16'd1;
    w_rem_next   = r_rem;
    w_sel_next   = r_sel;
    w_dir_next   = r_dir;
    w_step_next  = r_step;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    w_err_next   = r_err;
    w_enter_low  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = 16'd0;
        if (w_accept) begin
          w_sel_next = req_if.req_sel;
          w_dir_next = req_if.req_dir;
          w_rem_next = req_if.req_steps;
          w_err_next = 1'b0;
          if (req_if.req_steps != 8'd0) begin
            w_state_next = ST_SETUP;
          end else begin
            w_state_next = ST_WAIT_LOCK;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_enter_low  = 1'b1;
          w_state_next = ST_STEP_LOW;
          w_cnt_next   = 16'd0;
        end else begin
          w_state_next = ST_SETUP;
        end
      end
      ST_STEP_LOW: begin
        if (r_cnt == PULSE_LAST) begin
          w_step_next  = 1'b1;
          w_state_next = ST_STEP_HIGH;
          w_cnt_next   = 16'd0;
        end else begin
          w_state_next = ST_STEP_LOW;
        end
      end
      ST_STEP_HIGH: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_next = 16'd0;
          if (r_rem != 8'd0) begin
            w_enter_low  = 1'b1;
            w_state_next = ST_STEP_LOW;
          end else begin
            w_state_next = ST_WAIT_LOCK;
          end
        end else begin
          w_state_next = ST_STEP_HIGH;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout that expires in the same cycle.
        if (pll_locked) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_err_next   = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT_LOCK;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 16'd0;
        w_step_next  = 1'b1;
      end
    endcase

    if (w_enter_low) begin
      w_step_next  = 1'b0;
      w_rem_next   = r_rem - 8'd1;
      w_count_next = step_counter(r_count, r_sel, r_dir);
    end else begin
      w_count_next = w_count_next;
    end

    w_busy_next  = (w_state_next != ST_IDLE);
    w_ready_next = (r_state == ST_IDLE) && pll_locked && !w_accept;
  end

  // State and output registers; reset forces PHASESTEP idle-high immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_rem   <= 8'd0;
      r_sel   <= 2'd0;
      r_dir   <= 1'b1;
      r_step  <= 1'b1;
      r_count <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rem   <= w_rem_next;
      r_sel   <= w_sel_next;
      r_dir   <= w_dir_next;
      r_step  <= w_step_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_busy  <= w_busy_next;
      r_ready <= w_ready_next;
    end
  end

  assign req_if.req_ready = r_ready;
  assign req_if.done      = r_done;
  assign req_if.err       = r_err;
  assign req_if.busy      = r_busy;
  assign phase_count      = r_count;
  assign pll_phasesel     = r_sel;
  assign pll_phasedir     = r_dir;
  assign pll_phasestep    = r_step;
  assign pll_phaseloadreg = 1'b1;

endmodule

// File: tb/tb_ulx3s_pll_phase_stepper.sv
// Randomised self-checking bench: PHASESTEP waveform, done timing and counters are compared
// against expectations derived from the request timing rules and a per-output step tally.
module tb_ulx3s_pll_phase_stepper;
  localparam int SETUP  = 4;
  localparam int PULSE  = 4;
  localparam int GAP    = 8;
  localparam int PER    = PULSE + GAP;
  localparam int TO_CYC = 16;
  localparam int MAXC   = 600;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        lock_a = 1'b1;
  logic        lock_b = 1'b1;
  logic [31:0] pc_a, pc_b;
  logic [1:0]  sel_a, sel_b;
  logic        dir_a, dir_b, step_a, step_b, lreg_a, lreg_b;

  ulx3s_pll_phase_stepper_if bus_a ();
  ulx3s_pll_phase_stepper_if bus_b ();

  ulx3s_pll_phase_stepper dut (
    .clock(clock), .reset(reset), .req_if(bus_a.slave), .phase_count(pc_a),
    .pll_locked(lock_a), .pll_phasesel(sel_a), .pll_phasedir(dir_a),
    .pll_phasestep(step_a), .pll_phaseloadreg(lreg_a)
  );

  ulx3s_pll_phase_stepper #(.LOCK_TIMEOUT(TO_CYC)) dut_to (
    .clock(clock), .reset(reset), .req_if(bus_b.slave), .phase_count(pc_b),
    .pll_locked(lock_b), .pll_phasesel(sel_b), .pll_phasedir(dir_b),
    .pll_phasestep(step_b), .pll_phaseloadreg(lreg_b)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int mc[4];

  logic        cap_step [MAXC];
  logic        cap_done [MAXC];
  logic        cap_busy [MAXC];
  logic        cap_ready[MAXC];
  logic        cap_err  [MAXC];
  logic        cap_lreg [MAXC];
  logic [1:0]  cap_sel  [MAXC];
  logic        cap_dir  [MAXC];
  logic [31:0] cap_pc   [MAXC];

  function automatic logic exp_low(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if (k >= SETUP + i * PER && k < SETUP + i * PER + PULSE) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_done_k(input int n);
    return (n == 0) ? 1 : SETUP + n * PER + 1;
  endfunction

  function automatic logic [31:0] model_pc();
    logic [7:0] b0, b1, b2, b3;
    b0 = mc[0][7:0]; b1 = mc[1][7:0]; b2 = mc[2][7:0]; b3 = mc[3][7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic model_apply(input int s, input int d, input int n);
    if (d != 0) mc[s] = (mc[s] - n + 256) % 256;
    else        mc[s] = (mc[s] + n) % 256;
  endtask

  task automatic issue_a(input logic [1:0] s, input logic d, input logic [7:0] n, input logic hold);
    int guard = 0;
    @(negedge clock);
    while (bus_a.req_ready !== 1'b1 && guard < 300) begin @(negedge clock); guard++; end
    if (bus_a.req_ready !== 1'b1) begin
      checks++; errors++; $display("FAIL ready_wait got %b want 1", bus_a.req_ready);
    end
    bus_a.req_valid = 1'b1; bus_a.req_sel = s; bus_a.req_dir = d; bus_a.req_steps = n;
    @(posedge clock); #1;
    if (!hold) bus_a.req_valid = 1'b0;
  endtask

  task automatic capture_a(input int n, input int drop_at, input int raise_at, input int vdrop_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      cap_step[k] = step_a;  cap_done[k] = bus_a.done;  cap_busy[k] = bus_a.busy;
      cap_ready[k] = bus_a.req_ready; cap_err[k] = bus_a.err; cap_lreg[k] = lreg_a;
      cap_sel[k] = sel_a; cap_dir[k] = dir_a; cap_pc[k] = pc_a;
      if (k == drop_at)  lock_a = 1'b0;
      if (k == raise_at) lock_a = 1'b1;
      if (k == vdrop_at) bus_a.req_valid = 1'b0;
    end
  endtask

  task automatic analyse(input int n, input int steps, output int mism, output int falls,
                         output int first, output int dcnt, output int dfirst);
    mism = 0; falls = 0; first = -1; dcnt = 0; dfirst = -1;
    for (int k = 0; k < n; k++) begin
      if (cap_step[k] !== !exp_low(k, steps)) mism++;
      if (cap_step[k] === 1'b0 && (k == 0 || cap_step[k-1] === 1'b1)) begin
        falls++;
        if (first < 0) first = k;
      end
      if (cap_done[k] === 1'b1) begin
        dcnt++;
        if (dfirst < 0) dfirst = k;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++; if (bus_a.req_ready !== 1'b0 || bus_a.done !== 1'b0 || bus_a.err !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL rst_status got rdy%b done%b err%b busy%b want 0000", bus_a.req_ready, bus_a.done, bus_a.err, bus_a.busy); end
    checks++; if ({pc_a, sel_a, dir_a, step_a, lreg_a} !== {32'd0, 2'd0, 1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rst_pll got pc%h sel%0d dir%b step%b lreg%b want 0 0 1 1 1", pc_a, sel_a, dir_a, step_a, lreg_a); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus_a.req_ready); end
    // Reset in the middle of a low pulse.
    issue_a(2'd1, 1'b0, 8'd3, 1'b0);
    capture_a(SETUP + 1, -1, -1, -1);
    checks++; if (cap_step[SETUP] !== 1'b0) begin errors++; $display("FAIL rst_prepulse got %b want 0", cap_step[SETUP]); end
    #1 reset = 1'b1;
    #1;
    checks++; if (step_a !== 1'b1 || bus_a.busy !== 1'b0 || pc_a !== 32'd0) begin
      errors++; $display("FAIL rst_midpulse got step%b busy%b pc%h want 1 0 0", step_a, bus_a.busy, pc_a); end
    for (int i = 0; i < 4; i++) mc[i] = 0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready2 got %b want 1", bus_a.req_ready); end
  endtask

  task automatic test_lag();
    int dk, mism, falls, first, dcnt, dfirst;
    dk = exp_done_k(3);
    issue_a(2'd3, 1'b0, 8'd3, 1'b0);
    model_apply(3, 0, 3);
    capture_a(dk + 3, -1, -1, -1);
    analyse(dk + 3, 3, mism, falls, first, dcnt, dfirst);
    checks++; if (cap_sel[0] !== 2'd3 || cap_dir[0] !== 1'b0) begin errors++; $display("FAIL lag_seldir got %0d %b want 3 0", cap_sel[0], cap_dir[0]); end
    checks++; if (first != SETUP) begin errors++; $display("FAIL lag_first got %0d want %0d", first, SETUP); end
    checks++; if (falls != 3 || mism != 0) begin errors++; $display("FAIL lag_pulses got falls%0d mism%0d want 3 0", falls, mism); end
    checks++; if (dcnt != 1 || dfirst != dk) begin errors++; $display("FAIL lag_done got cnt%0d at%0d want 1 %0d", dcnt, dfirst, dk); end
    checks++; if (cap_pc[dk] !== model_pc()) begin errors++; $display("FAIL lag_count got %h want %h", cap_pc[dk], model_pc()); end
    checks++; if (cap_busy[0] !== 1'b1 || cap_busy[dk] !== 1'b0) begin errors++; $display("FAIL lag_busy got %b %b want 1 0", cap_busy[0], cap_busy[dk]); end
    checks++; if (cap_ready[dk] !== 1'b0 || cap_ready[dk+1] !== 1'b1) begin errors++; $display("FAIL lag_ready got %b %b want 0 1", cap_ready[dk], cap_ready[dk+1]); end
  endtask

  task automatic test_lead();
    int dk, mism, falls, first, dcnt, dfirst;
    dk = exp_done_k(5);
    issue_a(2'd3, 1'b1, 8'd5, 1'b0);
    model_apply(3, 1, 5);
    capture_a(dk + 2, -1, -1, -1);
    analyse(dk + 2, 5, mism, falls, first, dcnt, dfirst);
    checks++; if (cap_pc[dk] !== model_pc()) begin errors++; $display("FAIL lead_count got %h want %h", cap_pc[dk], model_pc()); end
    checks++; if (falls != 5 || mism != 0) begin errors++; $display("FAIL lead_pulses got falls%0d mism%0d want 5 0", falls, mism); end
    checks++; if (dfirst != dk) begin errors++; $display("FAIL lead_done got %0d want %0d", dfirst, dk); end
  endtask

  task automatic test_zero_steps();
    int mism, falls, first, dcnt, dfirst;
    issue_a(2'd2, 1'b0, 8'd0, 1'b0);
    capture_a(6, -1, -1, -1);
    analyse(6, 0, mism, falls, first, dcnt, dfirst);
    checks++; if (falls != 0 || mism != 0) begin errors++; $display("FAIL zero_pulses got falls%0d mism%0d want 0 0", falls, mism); end
    checks++; if (dcnt != 1 || dfirst != 1) begin errors++; $display("FAIL zero_done got cnt%0d at%0d want 1 1", dcnt, dfirst); end
    checks++; if (cap_pc[5] !== model_pc()) begin errors++; $display("FAIL zero_count got %h want %h", cap_pc[5], model_pc()); end
  endtask

  task automatic test_lock_drop();
    int raise_k, mism, falls, first, dcnt, dfirst;
    raise_k = SETUP + 2 * PER + 100;
    issue_a(2'd0, 1'b0, 8'd2, 1'b0);
    model_apply(0, 0, 2);
    capture_a(raise_k + 5, 2, raise_k, -1);
    analyse(raise_k + 5, 2, mism, falls, first, dcnt, dfirst);
    checks++; if (falls != 2 || mism != 0) begin errors++; $display("FAIL drop_pulses got falls%0d mism%0d want 2 0", falls, mism); end
    checks++; if (dcnt != 1 || dfirst != raise_k + 1) begin errors++; $display("FAIL drop_done got cnt%0d at%0d want 1 %0d", dcnt, dfirst, raise_k + 1); end
    checks++; if (cap_err[raise_k + 1] !== 1'b0) begin errors++; $display("FAIL drop_err got %b want 0", cap_err[raise_k + 1]); end
    checks++; if (cap_pc[raise_k + 1] !== model_pc()) begin errors++; $display("FAIL drop_count got %h want %h", cap_pc[raise_k + 1], model_pc()); end
  endtask

  task automatic test_timeout();
    int guard, dcnt, dfirst;
    for (int pass = 0; pass < 2; pass++) begin
      guard = 0;
      @(negedge clock);
      while (bus_b.req_ready !== 1'b1 && guard < 50) begin @(negedge clock); guard++; end
      if (bus_b.req_ready !== 1'b1) begin checks++; errors++; $display("FAIL to_ready_wait got %b want 1", bus_b.req_ready); end
      bus_b.req_valid = 1'b1; bus_b.req_sel = 2'd2; bus_b.req_dir = 1'b0; bus_b.req_steps = 8'd0;
      if (pass == 0) lock_b = 1'b0;
      @(posedge clock); #1; bus_b.req_valid = 1'b0;
      dcnt = 0; dfirst = -1;
      for (int k = 0; k < TO_CYC + 4; k++) begin
        @(negedge clock);
        cap_err[k] = bus_b.err; cap_done[k] = bus_b.done;
        if (bus_b.done === 1'b1) begin dcnt++; if (dfirst < 0) dfirst = k; end
      end
      if (pass == 0) begin
        checks++; if (dcnt != 1 || dfirst != TO_CYC) begin errors++; $display("FAIL to_done got cnt%0d at%0d want 1 %0d", dcnt, dfirst, TO_CYC); end
        checks++; if (cap_err[TO_CYC-1] !== 1'b0 || cap_err[TO_CYC] !== 1'b1 || cap_err[TO_CYC+3] !== 1'b1) begin
          errors++; $display("FAIL to_err got %b%b%b want 011", cap_err[TO_CYC-1], cap_err[TO_CYC], cap_err[TO_CYC+3]); end
        checks++; if (pc_b !== 32'd0) begin errors++; $display("FAIL to_count got %h want 0", pc_b); end
        lock_b = 1'b1;
      end else begin
        checks++; if (cap_err[0] !== 1'b0) begin errors++; $display("FAIL to_errclear got %b want 0", cap_err[0]); end
        checks++; if (dfirst != 1) begin errors++; $display("FAIL to_done2 got %0d want 1", dfirst); end
      end
    end
  endtask

  task automatic test_busy_hold();
    int dk, nready, nlreg, mism, falls, first, dcnt, dfirst;
    dk = exp_done_k(2);
    issue_a(2'd1, 1'b1, 8'd2, 1'b1);
    model_apply(1, 1, 2);
    capture_a(dk + 4, -1, -1, dk);
    analyse(dk + 4, 2, mism, falls, first, dcnt, dfirst);
    nready = 0; nlreg = 0;
    for (int k = 0; k <= dk; k++) if (cap_ready[k] !== 1'b0) nready++;
    for (int k = 0; k < dk + 4; k++) if (cap_lreg[k] !== 1'b1) nlreg++;
    checks++; if (nready != 0) begin errors++; $display("FAIL hold_ready got %0d high cycles want 0", nready); end
    checks++; if (nlreg != 0) begin errors++; $display("FAIL hold_loadreg got %0d low cycles want 0", nlreg); end
    checks++; if (falls != 2 || dcnt != 1) begin errors++; $display("FAIL hold_single got falls%0d done%0d want 2 1", falls, dcnt); end
    checks++; if (cap_busy[dk + 3] !== 1'b0 || cap_pc[dk + 3] !== model_pc()) begin
      errors++; $display("FAIL hold_after got busy%b pc%h want 0 %h", cap_busy[dk + 3], cap_pc[dk + 3], model_pc()); end
  endtask

  task automatic test_random();
    int s, d, n, dk, mism, falls, first, dcnt, dfirst;
    for (int it = 0; it < 8; it++) begin
      s = $urandom_range(0, 3); d = $urandom_range(0, 1); n = $urandom_range(0, 8);
      dk = exp_done_k(n);
      issue_a(s[1:0], d[0], n[7:0], 1'b0);
      model_apply(s, d, n);
      capture_a(dk + 2, -1, -1, -1);
      analyse(dk + 2, n, mism, falls, first, dcnt, dfirst);
      checks++; if (falls != n || mism != 0) begin errors++; $display("FAIL rnd%0d_pulses got falls%0d mism%0d want %0d 0", it, falls, mism, n); end
      checks++; if (dcnt != 1 || dfirst != dk) begin errors++; $display("FAIL rnd%0d_done got cnt%0d at%0d want 1 %0d", it, dcnt, dfirst, dk); end
      checks++; if (cap_pc[dk] !== model_pc()) begin errors++; $display("FAIL rnd%0d_count got %h want %h", it, cap_pc[dk], model_pc()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mc[i] = 0;
    bus_a.req_valid = 1'b0; bus_a.req_sel = 2'd0; bus_a.req_dir = 1'b0; bus_a.req_steps = 8'd0;
    bus_b.req_valid = 1'b0; bus_b.req_sel = 2'd0; bus_b.req_dir = 1'b0; bus_b.req_steps = 8'd0;
    test_reset();
    test_lag();
    test_lead();
    test_zero_steps();
    test_lock_drop();
    test_timeout();
    test_busy_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ulx3s_pll_phase_stepper.md
# ulx3s_pll_phase_stepper

Controller for the dynamic phase-shift port of the ECP5 EHXPLLL used by the ULX3S clock generators. It accepts a request (output select, direction, step count), sequences the PLL's PHASESEL/PHASEDIR/PHASESTEP strobes with the required setup and pulse widths, and tracks the accumulated phase offset of each PLL output. It then waits for LOCK before reporting completion. It sits beside the clock generator, runs on the I/O clock, and lets the SDRAM-control clock phase be trimmed at run time instead of fixed in the CPHASE parameters.

## Interface
- SETUP_CYCLES, 4: cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP low (≥1)
- PULSE_CYCLES, 4: PHASESTEP low width per step (≥1)
- GAP_CYCLES, 8: PHASESTEP high time after each pulse (≥1)
- LOCK_TIMEOUT, 65535: maximum cycles in WAIT_LOCK before error (16-bit counter)

- clock  in  1  controller clock (50 MHz clkIO)
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request strobe
- req_ready  out  1  high when IDLE and pll_locked high
- req_sel  in  2  output select: 0 CLKOP, 1 CLKOS, 2 CLKOS2, 3 CLKOS3
- req_dir  in  1  0 = lag (counter +1 per step), 1 = lead (counter −1 per step)
- req_steps  in  8  number of steps; 0 is legal
- done  out  1  one-cycle completion pulse
- err  out  1  sticky lock-timeout flag; cleared on the next accepted request
- busy  out  1  high in any state except IDLE
- phase_count  out  32  four 8-bit wrap-around step counters; [8k+7:8k] belongs to output k
- pll_locked  in  1  EHXPLLL LOCK (synchronised externally)
- pll_phasesel  out  2  to PHASESEL1:0
- pll_phasedir  out  1  to PHASEDIR
- pll_phasestep  out  1  to PHASESTEP, idle high, active low
- pll_phaseloadreg  out  1  to PHASELOADREG, held high (never pulsed)

## Operation
- Reset values: req_ready 0 (goes to pll_locked one cycle after reset is released); done 0; err 0; busy 0; phase_count 0; pll_phasesel 0; pll_phasedir 1; pll_phasestep 1; pll_phaseloadreg 1. These take effect immediately on reset assertion, including mid-pulse.
- Accept occurs when req_valid && req_ready at a rising edge. On accept, latch sel/dir/steps into pll_phasesel/pll_phasedir/remaining and clear err. req_* are ignored otherwise.
- States:
  - IDLE: on accept, go to SETUP if steps≠0, else go to WAIT_LOCK.
  - SETUP: wait SETUP_CYCLES, then go to STEP_LOW.
  - STEP_LOW: pll_phasestep=0 for PULSE_CYCLES. On entry, phase_count[sel] ±1 (mod 256) and remaining −1.
  - STEP_HIGH: pll_phasestep=1 for GAP_CYCLES. Then go to STEP_LOW if remaining≠0, else WAIT_LOCK.
  - WAIT_LOCK: when pll_locked=1, pulse done and go to IDLE. If LOCK_TIMEOUT cycles elapse, set err, pulse done, and go to IDLE.
- Between steps of one request, SETUP is not repeated; pll_phasesel/pll_phasedir stay stable from accept until the next accept.
- A pll_locked drop during SETUP/STEP states does not abort; remaining steps complete, then WAIT_LOCK absorbs relock.
- Counters wrap: 255 +1 → 0, 0 −1 → 255.

## Timing
- Accept at edge t0. pll_phasesel/dir are valid from t0 (registered at t0).
- First pll_phasestep low occurs in cycles t0+SETUP_CYCLES+1 … t0+SETUP_CYCLES+PULSE_CYCLES.
- Step period is PULSE_CYCLES+GAP_CYCLES.
- With lock held, done is high in cycle t0+1+SETUP_CYCLES+N·(PULSE_CYCLES+GAP_CYCLES)+1; with defaults and N=3 that is t0+42.
- N=0 with lock held: done is high in cycle t0+2; no PHASESTEP activity.
- done and the final phase_count value are both visible before req_ready returns high, which happens the cycle after done.
- busy rises the cycle after accept and falls with the return to IDLE.

## Test plan
- Reset mid-STEP_LOW: assert reset → pll_phasestep=1, busy=0, phase_count=0 immediately; after release and with lock high, req_ready=1 next cycle.
- sel=3, dir=0, steps=3, lock high → pll_phasesel=3, pll_phasedir=0; three low pulses of 4 cycles spaced 12 cycles apart; first falls 5 cycles after accept; phase_count[31:24]=3; done at t0+42.
- sel=3, dir=1, steps=5 starting from phase_count[31:24]=3 → value 254; other counters unchanged.
- steps=0 → no pulses; done 2 cycles after accept; counters unchanged.
- Lock dropped during steps and restored 100 cycles after the last gap → done the cycle lock returns, err=0. Lock held low with LOCK_TIMEOUT=16 → err=1 and done after 16 WAIT_LOCK cycles; next accept clears err.
- req_valid held high while busy → no second accept; req_ready=0 throughout; pll_phaseloadreg=1 always.
